// File: rtl/jump_motion_ctrl_if.sv
// Signal bundle between the jump controller and the position counter / game logic.
interface jump_motion_ctrl_if;
  logic       frame_tick;
  logic       jump_btn;
  logic       halt;
  logic [9:0] pos_q;
  logic       up;
  logic       dw;
  logic       CE;
  logic       LD;
  logic [9:0] D;
  logic       airborne;

  modport slave (
    input  frame_tick, jump_btn, halt, pos_q,
    output up, dw, CE, LD, D, airborne
  );

  modport master (
    output frame_tick, jump_btn, halt, pos_q,
    input  up, dw, CE, LD, D, airborne
  );
endinterface

// File: rtl/jump_motion_ctrl.sv
// Player jump arc controller: rise, hover at apex, fall, then snap to ground via
// the position counter's load input. One pixel per frame tick.
module jump_motion_ctrl #(
  parameter logic [9:0] GROUND       = 10'd400,
  parameter logic [9:0] JUMP_HEIGHT  = 10'd120,
  parameter int         HOVER_FRAMES = 16
) (
  input logic          clk,
  input logic          reset,
  jump_motion_ctrl_if.slave bus
);
  localparam logic [9:0] APEX = GROUND - JUMP_HEIGHT;
  localparam int HW = (HOVER_FRAMES > 1) ? $clog2(HOVER_FRAMES) : 1;
  localparam logic [HW-1:0] HOVER_LAST = HW'(HOVER_FRAMES - 1);

  typedef enum logic [2:0] {
    S_INIT, S_GROUND, S_RISE, S_HOVER, S_FALL, S_LAND
  } state_t;

  state_t        r_state;
  logic          r_up, r_dw, r_ld, r_airborne;
  logic [HW-1:0] r_hover_cnt;
  logic          r_btn_prev, r_jump_req;
  logic          w_step;

  // Motion only advances on a frame tick while not halted.
  assign w_step = bus.frame_tick & ~bus.halt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_INIT;
      r_up        <= 1'b0;
      r_dw        <= 1'b0;
      r_ld        <= 1'b0;
      r_airborne  <= 1'b0;
      r_hover_cnt <= '0;
      r_btn_prev  <= 1'b0;
      r_jump_req  <= 1'b0;
    end else begin
      r_up       <= 1'b0;
      r_dw       <= 1'b0;
      r_ld       <= 1'b0;
      r_btn_prev <= bus.jump_btn;
      // Requests only latch on the ground, so a held button cannot re-jump.
      if (r_state != S_GROUND)
        r_jump_req <= 1'b0;
      else if (bus.jump_btn && !r_btn_prev)
        r_jump_req <= 1'b1;

      unique case (r_state)
        S_INIT: begin
          r_ld    <= 1'b1;
          r_state <= S_GROUND;
        end
        S_GROUND: begin
          if (w_step && r_jump_req) begin
            r_jump_req <= 1'b0;
            r_airborne <= 1'b1;
            r_state    <= S_RISE;
          end
        end
        S_RISE: begin
          if (w_step) begin
            if (bus.pos_q > APEX) begin
              r_dw <= 1'b1;
            end else begin
              r_hover_cnt <= '0;
              r_state     <= S_HOVER;
            end
          end
        end
        S_HOVER: begin
          if (w_step) begin
            if (r_hover_cnt == HOVER_LAST) r_state <= S_FALL;
            else r_hover_cnt <= r_hover_cnt + 1'b1;
          end
        end
        S_FALL: begin
          if (w_step) begin
            if (bus.pos_q < GROUND) begin
              r_up <= 1'b1;
            end else begin
              r_airborne <= 1'b0;
              r_state    <= S_LAND;
            end
          end
        end
        S_LAND: begin
          r_ld    <= 1'b1;
          r_state <= S_GROUND;
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

  assign bus.up       = r_up;
  assign bus.dw       = r_dw;
  assign bus.LD       = r_ld;
  assign bus.airborne = r_airborne;
  assign bus.CE       = ~bus.halt;
  assign bus.D        = GROUND;
endmodule
